// File: rtl/spi_port_master_if.sv
// Shared Z80 CPU bus seen by I/O-port peripherals.
// Ports: a address, d write data, ioreq/rd/wr strobes (active high).
interface cpu_bus;
  logic [15:0] a;
  logic [7:0]  d;
  logic        ioreq;
  logic        rd;
  logic        wr;

  modport slave (
    input a, d, ioreq, rd, wr
  );

  modport master (
    output a, d, ioreq, rd, wr
  );
endinterface

// File: rtl/spi_port_master.sv
// Z80 I/O-port SPI master (mode 0) with N chip selects, SCK divider,
// one-deep TX hold register with overflow flag and optional read-ahead.
// Ports: rst_n/clk28, en, bus (cpu_bus.slave), d_out/d_out_active read
// path, sd_miso/sd_mosi/sd_sck/sd_cs SPI pins, spi_wait CPU wait request.
// Build option: define SPI_READAHEAD_EN to implement the ra config bit.
module spi_port_master #(
  parameter int         CS_COUNT  = 2,
  parameter logic [7:0] DATA_PORT = 8'hEB,
  parameter logic [7:0] CS_PORT   = 8'hE7,
  parameter logic [7:0] CFG_PORT  = 8'hEF
) (
  input  logic                rst_n,
  input  logic                clk28,
  input  logic                en,
  cpu_bus.slave               bus,
  output logic [7:0]          d_out,
  output logic                d_out_active,
  input  logic                sd_miso,
  output logic                sd_mosi,
  output logic                sd_sck,
  output logic [CS_COUNT-1:0] sd_cs,
  output logic                spi_wait
);

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, DONE
  } state_e;

  // strobe bits: {cfg_rd, cfg_wr, cs_wr, data_rd, data_wr}
  logic [4:0] stb_d;
  logic [4:0] stb_q;
  logic [4:0] stb_p_q;
  logic [4:0] fire;
  logic [7:0] d_q;

  logic data_wr_f, data_rd_f, cs_wr_f, cfg_wr_f, cfg_rd_f;

  state_e        state_q;
  logic          sck_q;
  logic          mosi_q;
  logic [7:0]    sh_q;
  logic [7:0]    tx_q;
  logic [7:0]    hold_q;
  logic [7:0]    rx_q;
  logic [2:0]    hc_q;
  logic [3:0]    ec_q;
  logic          pending_q;
  logic          ovf_q;
  logic [2:0]    div_q;
  logic [CS_COUNT-1:0] cs_q;
  logic          sel_cfg_q;
  logic [7:0]    stat_q;

  logic          ra;
  logic          busy;
  logic [7:0]    stat;
  logic          q_req;
  logic [7:0]    q_byte;
  logic          sel_cfg;
  logic          unused_a;

  assign unused_a = ^bus.a[15:8];

  always_comb begin
    stb_d = '0;
    if (en && bus.ioreq) begin
      stb_d[0] = bus.wr && (bus.a[7:0] == DATA_PORT);
      stb_d[1] = bus.rd && (bus.a[7:0] == DATA_PORT);
      stb_d[2] = bus.wr && (bus.a[7:0] == CS_PORT);
      stb_d[3] = bus.wr && (bus.a[7:0] == CFG_PORT);
      stb_d[4] = bus.rd && (bus.a[7:0] == CFG_PORT);
    end
  end

  assign fire      = stb_q & ~stb_p_q;
  assign data_wr_f = fire[0];
  assign data_rd_f = fire[1];
  assign cs_wr_f   = fire[2];
  assign cfg_wr_f  = fire[3];
  assign cfg_rd_f  = fire[4];

  assign busy  = (state_q != IDLE);
  assign stat  = {busy, pending_q, ovf_q, 1'b0, ra, div_q};

  // a data write wins over a read-ahead request in the same cycle
  assign q_req  = data_wr_f | (data_rd_f & ra);
  assign q_byte = data_wr_f ? d_q : 8'hFF;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      stb_q     <= '0;
      stb_p_q   <= '0;
      d_q       <= '0;
      div_q     <= 3'd1;
      cs_q      <= '1;
      sel_cfg_q <= 1'b0;
      stat_q    <= 8'h01;
    end else begin
      stb_q   <= stb_d;
      stb_p_q <= stb_q;
      d_q     <= bus.d;
      if (cs_wr_f)  cs_q  <= d_q[CS_COUNT-1:0];
      if (cfg_wr_f) div_q <= d_q[2:0];
      if (cfg_rd_f) begin
        sel_cfg_q <= 1'b1;
        stat_q    <= stat;
      end else if (data_rd_f) begin
        sel_cfg_q <= 1'b0;
      end
    end
  end

`ifdef SPI_READAHEAD_EN
  logic ra_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ra_q <= 1'b0;
    end else if (cfg_wr_f) begin
      ra_q <= d_q[3];
    end
  end

  assign ra = ra_q;
`else
  assign ra = 1'b0;
`endif

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b1;
      sh_q      <= '0;
      tx_q      <= '0;
      hold_q    <= '0;
      rx_q      <= 8'hFF;
      hc_q      <= '0;
      ec_q      <= '0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (cfg_rd_f) ovf_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (q_req) begin
            tx_q    <= q_byte;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          sh_q    <= tx_q;
          mosi_q  <= tx_q[7];
          hc_q    <= div_q;
          ec_q    <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (hc_q == 3'd0) begin
            hc_q  <= div_q;
            sck_q <= ~sck_q;
            ec_q  <= ec_q + 4'd1;
            if (!sck_q) begin
              sh_q <= {sh_q[6:0], sd_miso};
            end else if (ec_q == 4'd15) begin
              mosi_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              mosi_q <= sh_q[7];
            end
          end else begin
            hc_q <= hc_q - 3'd1;
          end
        end
        DONE: begin
          rx_q <= sh_q;
          if (pending_q) begin
            tx_q      <= hold_q;
            pending_q <= 1'b0;
            state_q   <= LOAD;
          end else if (q_req) begin
            tx_q    <= q_byte;
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // requests that cannot launch directly go to hold or overflow
      if (q_req && (state_q == LOAD || state_q == SHIFT ||
                    (state_q == DONE && pending_q))) begin
        if (pending_q) begin
          ovf_q <= 1'b1;
        end else begin
          hold_q    <= q_byte;
          pending_q <= 1'b1;
        end
      end
    end
  end

  // the read-start cycle shows live status; later cycles the snapshot
  assign sel_cfg = cfg_rd_f ? 1'b1 :
                   data_rd_f ? 1'b0 : sel_cfg_q;

  assign d_out        = sel_cfg ? (cfg_rd_f ? stat : stat_q) : rx_q;
  assign d_out_active = stb_q[1] | stb_q[4];
  assign sd_mosi      = mosi_q;
  assign sd_sck       = sck_q;
  assign sd_cs        = cs_q;
  assign spi_wait     = busy | pending_q;

endmodule
